// File: rtl/secuencia_programar.sv
// secuencia_programar
// Walks the RTC write-bus programming sequence and drives the 5-bit ctrl_W
// code to the write-path decoder:
//   INIT  steps 0-6   : 10110 10111 11010 11000 11001 11011 11100
//   REGS  steps 7-26  : 00001 .. 10100 (code = step - 6, address then data)
//   FIN   step 27     : 10101
//   HANDOFF           : 11101 for one clock with done_W, then back to IDLE
// Every INIT/REGS/FIN code is held HOLD_CYC clocks.
// Optional feature macro: PROG_ABORT_EN adds abort_W, which jumps from
// INIT/REGS straight to FIN and then returns to IDLE without HANDOFF.
module secuencia_programar #(
    parameter int HOLD_CYC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_W,
`ifdef PROG_ABORT_EN
    input  logic       abort_W,
`endif
    output logic [4:0] ctrl_W,
    output logic       busy_W,
    output logic       done_W,
    output logic [4:0] step_W
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_REGS    = 3'd2;
    localparam logic [2:0] ST_FIN     = 3'd3;
    localparam logic [2:0] ST_HANDOFF = 3'd4;

    localparam int             CNT_W    = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [4:0] CODE_IDLE     = 5'b00000;
    localparam logic [4:0] CODE_FIN      = 5'b10101;
    localparam logic [4:0] CODE_RD_START = 5'b11101;

    localparam logic [4:0] STEP_INIT_LAST = 5'd6;
    localparam logic [4:0] STEP_REGS_LAST = 5'd26;
    localparam logic [4:0] STEP_FIN       = 5'd27;

    logic [2:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             aborted;
    logic             abort_req;
    logic             hold_done;
    logic [4:0]       next_step;

`ifdef PROG_ABORT_EN
    assign abort_req = abort_W;
`else
    assign abort_req = 1'b0;
`endif

    assign hold_done = (hold_cnt == CNT_LAST);
    assign next_step = step_W + 5'd1;

    // Code presented to the decoder for a given step index.
    function automatic logic [4:0] code_of_step(input logic [4:0] s);
        case (s)
            5'd0:    code_of_step = 5'b10110;
            5'd1:    code_of_step = 5'b10111;
            5'd2:    code_of_step = 5'b11010;
            5'd3:    code_of_step = 5'b11000;
            5'd4:    code_of_step = 5'b11001;
            5'd5:    code_of_step = 5'b11011;
            5'd6:    code_of_step = 5'b11100;
            5'd27:   code_of_step = CODE_FIN;
            default: code_of_step = s - 5'd6;
        endcase
    endfunction

    // Sequencer: state, hold counter and all registered outputs.
    // NOTE: every register here uses <= so all of them update from the
    // values present before the edge; a blocking = would let later
    // statements see half-updated state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            aborted  <= 1'b0;
            ctrl_W   <= CODE_IDLE;
            busy_W   <= 1'b0;
            done_W   <= 1'b0;
            step_W   <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_W  <= 1'b0;
                    aborted <= 1'b0;
                    if (start_W) begin
                        state    <= ST_INIT;
                        step_W   <= 5'd0;
                        ctrl_W   <= code_of_step(5'd0);
                        busy_W   <= 1'b1;
                        hold_cnt <= '0;
                    end
                end

                ST_INIT, ST_REGS: begin
                    if (abort_req) begin
                        // Abort skips the remaining registers but still
                        // emits the finish code for a full hold period.
                        state    <= ST_FIN;
                        step_W   <= STEP_FIN;
                        ctrl_W   <= CODE_FIN;
                        hold_cnt <= '0;
                        aborted  <= 1'b1;
                    end else if (hold_done) begin
                        hold_cnt <= '0;
                        step_W   <= next_step;
                        ctrl_W   <= code_of_step(next_step);
                        if (state == ST_INIT && step_W == STEP_INIT_LAST)
                            state <= ST_REGS;
                        else if (state == ST_REGS && step_W == STEP_REGS_LAST)
                            state <= ST_FIN;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end

                ST_FIN: begin
                    if (hold_done) begin
                        hold_cnt <= '0;
                        if (aborted) begin
                            state  <= ST_IDLE;
                            ctrl_W <= CODE_IDLE;
                            busy_W <= 1'b0;
                            step_W <= 5'd0;
                        end else begin
                            state  <= ST_HANDOFF;
                            ctrl_W <= CODE_RD_START;
                            done_W <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end

                ST_HANDOFF: begin
                    // start_W is deliberately not sampled on this edge.
                    state  <= ST_IDLE;
                    ctrl_W <= CODE_IDLE;
                    busy_W <= 1'b0;
                    done_W <= 1'b0;
                    step_W <= 5'd0;
                end

                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    aborted  <= 1'b0;
                    ctrl_W   <= CODE_IDLE;
                    busy_W   <= 1'b0;
                    done_W   <= 1'b0;
                    step_W   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuencia_programar.sv
// tb_secuencia_programar
// Directed bench: one instance at HOLD_CYC=10 and one at HOLD_CYC=1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_secuencia_programar;

    logic       clk;
    logic       reset;
    logic       start10, start1;
    logic [4:0] ctrl10, ctrl1, step10, step1;
    logic       busy10, busy1, done10, done1;
`ifdef PROG_ABORT_EN
    logic       abort10, abort1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Hand-written code table, index = step.
    logic [4:0] exp_code [0:27] = '{
        5'b10110, 5'b10111, 5'b11010, 5'b11000, 5'b11001, 5'b11011, 5'b11100,
        5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
        5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110,
        5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101
    };

    secuencia_programar #(.HOLD_CYC(10)) dut10 (
        .clk     (clk),
        .reset   (reset),
        .start_W (start10),
`ifdef PROG_ABORT_EN
        .abort_W (abort10),
`endif
        .ctrl_W  (ctrl10),
        .busy_W  (busy10),
        .done_W  (done10),
        .step_W  (step10)
    );

    secuencia_programar #(.HOLD_CYC(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .start_W (start1),
`ifdef PROG_ABORT_EN
        .abort_W (abort1),
`endif
        .ctrl_W  (ctrl1),
        .busy_W  (busy1),
        .done_W  (done1),
        .step_W  (step1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs c clocks after the start edge, from the sequence timing.
    task automatic check_cycle(input string run, input int c, input int hold,
                               input logic [4:0] ctrl, input logic [4:0] step,
                               input logic busy, input logic done);
        logic [4:0] e_ctrl, e_step;
        logic       e_busy, e_done;
        if (c < 28 * hold) begin
            e_ctrl = exp_code[c / hold]; e_step = 5'(c / hold); e_busy = 1'b1; e_done = 1'b0;
        end else if (c == 28 * hold) begin
            e_ctrl = 5'b11101; e_step = 5'd27; e_busy = 1'b1; e_done = 1'b1;
        end else begin
            e_ctrl = 5'b00000; e_step = 5'd0; e_busy = 1'b0; e_done = 1'b0;
        end
        check($sformatf("%s ctrl c=%0d", run, c), 32'(ctrl), 32'(e_ctrl));
        check($sformatf("%s step c=%0d", run, c), 32'(step), 32'(e_step));
        check($sformatf("%s busy c=%0d", run, c), 32'(busy), 32'(e_busy));
        check($sformatf("%s done c=%0d", run, c), 32'(done), 32'(e_done));
        check($sformatf("%s legal c=%0d", run, c), 32'(ctrl[4:1] != 4'b1111), 32'd1);
    endtask

    initial begin
        int done_cnt;
        reset   = 1'b1;
        start10 = 1'b0;
        start1  = 1'b0;
`ifdef PROG_ABORT_EN
        abort10 = 1'b0;
        abort1  = 1'b0;
`endif
        #1;
        check("reset ctrl", 32'(ctrl10), 32'd0);
        check("reset busy", 32'(busy10), 32'd0);
        check("reset done", 32'(done10), 32'd0);
        check("reset step", 32'(step10), 32'd0);
        check("reset ctrl h1", 32'(ctrl1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle ctrl", 32'(ctrl10), 32'd0);

        // Run 1: HOLD_CYC=10, start pulse, start toggled during REGS.
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        done_cnt = 0;
        for (int c = 0; c <= 290; c++) begin
            if (c != 0) @(negedge clk);
            check_cycle("h10", c, 10, ctrl10, step10, busy10, done10);
            if (done10) done_cnt++;
            start10 = (c >= 100 && c <= 150) ? ((c % 2) == 0) : 1'b0;
        end
        check("h10 done pulses", 32'(done_cnt), 32'd1);

        // Run 2: HOLD_CYC=1, start held high -> 29 clocks, one idle, restart.
        start1 = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 29; c++) begin
            if (c != 0) @(negedge clk);
            check_cycle("h1", c, 1, ctrl1, step1, busy1, done1);
        end
        @(negedge clk);
        check("h1 restart ctrl", 32'(ctrl1), 32'b10110);
        check("h1 restart busy", 32'(busy1), 32'd1);
        start1 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check_cycle("h1b", c, 1, ctrl1, step1, busy1, done1);
        end

        // Run 3: reset in the middle of step 18, then restart.
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        for (int c = 0; c <= 180; c++) begin
            if (c != 0) @(negedge clk);
            check_cycle("rst", c, 10, ctrl10, step10, busy10, done10);
        end
        check("rst pre ctrl", 32'(ctrl10), 32'b01100);
        #1 reset = 1'b1;
        #1;
        check("rst async ctrl", 32'(ctrl10), 32'd0);
        check("rst async busy", 32'(busy10), 32'd0);
        check("rst async step", 32'(step10), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        check("rst restart ctrl", 32'(ctrl10), 32'b10110);
        check("rst restart busy", 32'(busy10), 32'd1);
        for (int c = 1; c <= 285; c++) begin
            @(negedge clk);
            check_cycle("rst2", c, 10, ctrl10, step10, busy10, done10);
        end

`ifdef PROG_ABORT_EN
        // Run 4: abort at step 9 (code 00011).
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        for (int c = 0; c <= 92; c++) begin
            if (c != 0) @(negedge clk);
            check_cycle("abt", c, 10, ctrl10, step10, busy10, done10);
        end
        abort10 = 1'b1;
        for (int c = 93; c <= 105; c++) begin
            @(negedge clk);
            abort10 = 1'b0;
            check($sformatf("abt ctrl c=%0d", c), 32'(ctrl10),
                  (c <= 102) ? 32'b10101 : 32'd0);
            check($sformatf("abt busy c=%0d", c), 32'(busy10), (c <= 102) ? 32'd1 : 32'd0);
            check($sformatf("abt done c=%0d", c), 32'(done10), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
